// File: rtl/system.sv
`timescale 1ns/1ps
// UART echo subsystem: 8N1 receiver, one-byte echo holding register and
// 8N1 transmitter, with received-byte counter and sticky error flags.
module system #(
  parameter int DIVIDER = 156,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             rxd,
  output logic             txd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic [CNT_W-1:0] rx_count,
  output logic             frame_err,
  output logic             overrun,
  output logic             tx_busy
);

  localparam int TW = $clog2(DIVIDER);
  localparam logic [TW-1:0] FULL_BIT = TW'(DIVIDER - 1);
  localparam logic [TW-1:0] HALF_BIT = TW'(DIVIDER / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Synchroniser
  logic rx_meta;
  logic rxs;

  // Receiver
  rx_state_t     rx_state;
  logic [TW-1:0] rx_timer;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_armed;

  // Echo holding register
  logic       hold_full;
  logic [7:0] hold_byte;

  // Transmitter
  tx_state_t     tx_state;
  logic [TW-1:0] tx_timer;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_ready;
  logic          tx_launch;

  // Two-flop synchroniser for the asynchronous receive line, idling high
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM: centre-sampled start/data/stop bits, publishes good bytes
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rx_state  <= RX_IDLE;
      rx_timer  <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      rx_armed  <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_count  <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          // A start is only accepted once the line has been seen high,
          // so a line still low after a bad stop bit does not retrigger.
          if (rxs) begin
            rx_armed <= 1'b1;
          end else if (rx_armed) begin
            rx_state <= RX_START;
            rx_timer <= HALF_BIT;
            rx_armed <= 1'b0;
          end
        end
        RX_START: begin
          if (rx_timer != '0) begin
            rx_timer <= rx_timer - 1'b1;
          end else if (rxs) begin
            rx_state <= RX_IDLE;
            rx_armed <= 1'b1;
          end else begin
            rx_state <= RX_DATA;
            rx_timer <= FULL_BIT;
            rx_idx   <= '0;
          end
        end
        RX_DATA: begin
          if (rx_timer != '0) begin
            rx_timer <= rx_timer - 1'b1;
          end else begin
            rx_shift[rx_idx] <= rxs;
            rx_timer         <= FULL_BIT;
            if (rx_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end
        end
        RX_STOP: begin
          if (rx_timer != '0) begin
            rx_timer <= rx_timer - 1'b1;
          end else begin
            rx_state <= RX_IDLE;
            rx_armed <= rxs;
            if (rxs) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              rx_count <= rx_count + 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // The transmitter can take a new byte when idle or in the last stop-bit cycle
  always_comb begin
    tx_ready  = (tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_timer == '0));
    tx_launch = hold_full && tx_ready;
  end

  // Echo holding register: newest byte wins, overrun when a full slot is overwritten
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      hold_full <= 1'b0;
      hold_byte <= '0;
      overrun   <= 1'b0;
    end else begin
      if (rx_valid) begin
        hold_byte <= rx_data;
        hold_full <= 1'b1;
        // A launch in the same cycle empties the slot, so no byte is lost.
        if (hold_full && !tx_launch) begin
          overrun <= 1'b1;
        end
      end else if (tx_launch) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Transmit FSM: start bit, eight data bits LSB first, stop bit
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_launch) begin
            tx_state <= TX_START;
            tx_shift <= hold_byte;
            tx_timer <= FULL_BIT;
            txd      <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_timer != '0) begin
            tx_timer <= tx_timer - 1'b1;
          end else begin
            tx_state <= TX_DATA;
            tx_timer <= FULL_BIT;
            tx_idx   <= '0;
            txd      <= tx_shift[0];
          end
        end
        TX_DATA: begin
          if (tx_timer != '0) begin
            tx_timer <= tx_timer - 1'b1;
          end else begin
            tx_timer <= FULL_BIT;
            if (tx_idx == 3'd7) begin
              tx_state <= TX_STOP;
              txd      <= 1'b1;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd      <= tx_shift[1];
            end
          end
        end
        TX_STOP: begin
          if (tx_timer != '0) begin
            tx_timer <= tx_timer - 1'b1;
          end else if (tx_launch) begin
            // Back-to-back: the next start bit directly follows this stop bit.
            tx_state <= TX_START;
            tx_shift <= hold_byte;
            tx_timer <= FULL_BIT;
            txd      <= 1'b0;
          end else begin
            tx_state <= TX_IDLE;
            tx_busy  <= 1'b0;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  rx_valid_single: assert property (@(posedge clk) disable iff (!resetb) rx_valid |=> !rx_valid);
  tx_idle_high:    assert property (@(posedge clk) disable iff (!resetb) !tx_busy |-> txd);

endmodule

// File: tb/tb_system.sv
`timescale 1ns/1ps
// Bench for the UART echo subsystem: serial stimulus on rxd, a timeline
// model of receive events, the echo slot and the transmit waveform, and a
// per-cycle output comparison plus literal checkpoints.
module tb_system;

  localparam int DIV    = 156;
  // 2 synchroniser flops + 1 cycle to detect the start + half bit + 9 bits
  localparam int RX_LAT = 3 + DIV / 2 + 9 * DIV;
  localparam int TX_LEN = 10 * DIV;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       rxd = 1'b1;
  logic       txd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] rx_count;
  logic       frame_err;
  logic       overrun;
  logic       tx_busy;

  system #(.DIVIDER(DIV), .CNT_W(8)) dut (
    .clk      (clk),
    .resetb   (resetb),
    .rxd      (rxd),
    .txd      (txd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_count (rx_count),
    .frame_err(frame_err),
    .overrun  (overrun),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int         at;
    logic [7:0] data;
    bit         ok;
  } rx_ev_t;
  rx_ev_t evq[$];

  // Model state
  logic [7:0] m_data;
  logic [7:0] m_count;
  bit         m_ferr;
  bit         m_ovr;
  bit         m_valid;
  bit         m_full;
  logic [7:0] m_hold;
  int         m_tx_start;
  logic [7:0] m_tx_byte;
  int         m_tx_free;

  task automatic model_reset();
    m_data     = '0;
    m_count    = '0;
    m_ferr     = 0;
    m_ovr      = 0;
    m_valid    = 0;
    m_full     = 0;
    m_hold     = '0;
    m_tx_start = -100000;
    m_tx_byte  = '0;
    m_tx_free  = 0;
    evq.delete();
  endtask

  function automatic bit in_tx(int n);
    return (n >= m_tx_start) && (n < m_tx_start + TX_LEN);
  endfunction

  function automatic logic exp_txd(int n);
    int k;
    if (!in_tx(n)) return 1'b1;
    k = (n - m_tx_start) / DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_tx_byte[k-1];
  endfunction

  // Advance the model to the state just after edge n.
  task automatic step_model(int n);
    bit     launch;
    rx_ev_t ev;
    if (!resetb) begin
      model_reset();
    end else begin
      launch = m_full && (n >= m_tx_free);
      if (launch) begin
        m_tx_start = n;
        m_tx_byte  = m_hold;
        m_tx_free  = n + TX_LEN;
      end
      if (m_valid) begin
        if (m_full && !launch) m_ovr = 1;
        m_hold = m_data;
        m_full = 1;
      end else if (launch) begin
        m_full = 0;
      end
      m_valid = 0;
      if (evq.size() > 0 && evq[0].at == n) begin
        ev = evq.pop_front();
        if (ev.ok) begin
          m_valid = 1;
          m_data  = ev.data;
          m_count = m_count + 8'd1;
        end else begin
          m_ferr = 1;
        end
      end
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      step_model(edge_n);
      n_assert++;
      if ({txd, tx_busy, rx_valid, rx_data, rx_count, frame_err, overrun} !==
          {exp_txd(edge_n), in_tx(edge_n), m_valid, m_data, m_count, m_ferr, m_ovr}) begin
        n_fail++;
        $display("FAIL outputs @edge %0d: got txd=%b busy=%b valid=%b data=%h count=%0d ferr=%b ovr=%b, expected txd=%b busy=%b valid=%b data=%h count=%0d ferr=%b ovr=%b",
                 edge_n, txd, tx_busy, rx_valid, rx_data, rx_count, frame_err, overrun,
                 exp_txd(edge_n), in_tx(edge_n), m_valid, m_data, m_count, m_ferr, m_ovr);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after an edge; drives one frame and registers its expected outcome.
  task automatic send_frame(input logic [7:0] data, input bit ok, input int stop_len);
    evq.push_back('{edge_n + RX_LAT, data, ok});
    rxd = 1'b0;
    wait_cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      wait_cycles(DIV);
    end
    rxd = ok;
    wait_cycles(stop_len);
    rxd = 1'b1;
  endtask

  initial begin
    int e;
    int gap;
    bit ok;
    logic [7:0] d;

    // Reset
    resetb = 1'b0;
    rxd    = 1'b1;
    #77;
    check("rst_txd", txd, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_tx_busy", tx_busy, 0);
    resetb = 1'b1;
    wait_cycles(1000);
    check("idle_txd", txd, 1);
    check("idle_tx_busy", tx_busy, 0);

    // Single byte and its echo timing
    e = edge_n;
    fork
      send_frame(8'h41, 1, DIV);
      begin
        wait_until(e + RX_LAT);
        check("b41_valid", rx_valid, 1);
        check("b41_data", rx_data, 32'h41);
        wait_until(e + RX_LAT + 1);
        check("b41_valid_pulse", rx_valid, 0);
        check("echo_not_yet", txd, 1);
        wait_until(e + RX_LAT + 2);
        check("echo_start_txd", txd, 0);
        check("echo_start_busy", tx_busy, 1);
      end
    join
    check("b41_count", rx_count, 1);
    check("b41_ferr", frame_err, 0);
    wait_until(e + RX_LAT + 2 + DIV + DIV / 2);
    check("echo_bit0", txd, 1);
    wait_until(e + RX_LAT + 2 + 2 * DIV + DIV / 2);
    check("echo_bit1", txd, 0);
    wait_until(e + RX_LAT + 2 + TX_LEN - 1);
    check("echo_busy_last", tx_busy, 1);
    wait_until(e + RX_LAT + 2 + TX_LEN);
    check("echo_busy_done", tx_busy, 0);

    // Glitch shorter than half a bit
    wait_cycles(50);
    rxd = 1'b0;
    wait_cycles(40);
    rxd = 1'b1;
    wait_cycles(400);
    check("glitch_count", rx_count, 1);
    check("glitch_ferr", frame_err, 0);
    check("glitch_txd", txd, 1);

    // Framing error (stop bit low)
    send_frame(8'h55, 0, DIV);
    wait_cycles(300);
    check("ferr_flag", frame_err, 1);
    check("ferr_count", rx_count, 1);
    check("ferr_txd", txd, 1);

    // Back-to-back burst with short stop bits: the echo falls behind until a
    // held byte is overwritten.
    for (int i = 0; i < 26; i++) begin
      d = (i < 3) ? 8'(i + 1) : 8'($urandom);
      send_frame(d, 1, 90);
    end
    wait_cycles(4000);
    check("burst_overrun", overrun, 1);
    check("burst_count", rx_count, 27);
    check("burst_ferr", frame_err, 1);

    // Random frames, gaps and stop lengths
    for (int i = 0; i < 6; i++) begin
      gap = $urandom_range(4, 400);
      wait_cycles(gap);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(8'($urandom), ok, ok ? $urandom_range(90, DIV) : DIV);
    end
    wait_cycles(4000);

    // Reset in the middle of an echo and a reception
    e = edge_n;
    send_frame(8'hA5, 1, DIV);
    wait_until(e + RX_LAT + 2 + 300);
    rxd = 1'b0;
    wait_cycles(400);
    #3;
    resetb = 1'b0;
    #1;
    check("mid_rst_txd", txd, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_count", rx_count, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_ovr", overrun, 0);
    rxd = 1'b1;
    wait_cycles(3);
    resetb = 1'b1;
    wait_cycles(20);

    // Recovery after reset
    e = edge_n;
    send_frame(8'h3C, 1, DIV);
    wait_until(e + RX_LAT + 2 + TX_LEN + 10);
    check("post_rst_count", rx_count, 1);
    check("post_rst_data", rx_data, 32'h3C);
    check("post_rst_txd", txd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
